// File: rtl/enc213_pkg.sv
// -----------------------------------------------------------------------------
// enc213_pkg
// Shared constants, FSM state type and parity helper for the rate-1/2,
// memory-3 (2,1,3) convolutional encoder.
// Generator bit order: bit3 = current input bit, bit0 = oldest stored bit.
// -----------------------------------------------------------------------------
package enc213_pkg;

  localparam int ENC_N = 2;  // code bits per symbol
  localparam int ENC_K = 1;  // info bits per symbol
  localparam int ENC_M = 3;  // encoder memory (shift register length)

  localparam logic [3:0] ENC_G0_DEFAULT = 4'b1111;
  localparam logic [3:0] ENC_G1_DEFAULT = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    TAIL = 2'b10
  } enc_state_t;

  // Modulo-2 sum of the register taps selected by generator g.
  function automatic logic conv_parity(input logic [ENC_M:0] u,
                                       input logic [ENC_M:0] g);
    return ^(u & g);
  endfunction

endpackage

// File: rtl/conv_enc213_core.sv
// -----------------------------------------------------------------------------
// conv_enc213_core
// Holds the 3-bit encoder shift register and forms the 2-bit code symbol for
// the bit presented on bit_i combinationally from the current register.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset, clears the register
//   shift_en_i in   advance the register by one bit (bit_i enters as newest)
//   bit_i      in   input bit for the symbol being formed
//   clear_i    in   synchronous clear of the register
//   sym_o      out  {G0 parity, G1 parity} for u = {bit_i, sr}
// -----------------------------------------------------------------------------
module conv_enc213_core
  import enc213_pkg::*;
#(
  parameter logic [ENC_M:0] G0 = ENC_G0_DEFAULT,
  parameter logic [ENC_M:0] G1 = ENC_G1_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en_i,
  input  logic             bit_i,
  input  logic             clear_i,
  output logic [ENC_N-1:0] sym_o
);

  // sr_q[2] is the newest stored bit, sr_q[0] the oldest.
  logic [ENC_M-1:0] sr_q;
  logic [ENC_M-1:0] sr_d;
  logic [ENC_M:0]   u;

  assign u     = {bit_i, sr_q};
  assign sym_o = {conv_parity(u, G0), conv_parity(u, G1)};

  // Next register value: clear, shift in the new bit, or hold.
  always_comb begin
    sr_d = sr_q;
    if (clear_i) begin
      sr_d = {ENC_M{1'b0}};
    end else if (shift_en_i) begin
      sr_d = u[ENC_M:1];
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register state.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q <= {ENC_M{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/conv_encoder_213.sv
// -----------------------------------------------------------------------------
// conv_encoder_213
// Rate-1/2, memory-3, 8-state convolutional encoder with frame markers and a
// single-slot registered output stage. One info bit in per handshake, one
// 2-bit code symbol out, one cycle of latency.
// Optional feature macro: CONV_ENC_TAIL_FLUSH_EN
//   defined   : each frame is followed by 3 zero tail symbols, so every frame
//               starts and ends in trellis state 0.
//   undefined : continuous trellis, the register carries across frames and
//               tx_sop/tx_eop are markers only.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   din        in   info bit
//   din_valid  in   din is valid
//   din_ready  out  encoder accepts din this cycle (combinational, no path
//                   from din_valid)
//   Tx         out  code symbol, Tx[1] = G0 parity, Tx[0] = G1 parity
//   tx_valid   out  Tx is valid
//   tx_ready   in   downstream accepts Tx this cycle
//   tx_sop     out  first symbol of frame
//   tx_eop     out  last symbol of frame
//   busy       out  frame in progress
// -----------------------------------------------------------------------------
module conv_encoder_213
  import enc213_pkg::*;
#(
  parameter logic [3:0]  G0        = ENC_G0_DEFAULT,
  parameter logic [3:0]  G1        = ENC_G1_DEFAULT,
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] Tx,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       busy
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
`ifdef CONV_ENC_TAIL_FLUSH_EN
  localparam logic TAIL_EN = 1'b1;
`else
  localparam logic TAIL_EN = 1'b0;
`endif

  enc_state_t       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]       tail_cnt_q, tail_cnt_d;
  logic [1:0]       tx_q, tx_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;

  logic       slot_free;
  logic       accept;
  logic       tail_fire;
  logic       last_bit;
  logic       last_tail;
  logic       core_bit;
  logic       shift_en;
  logic [1:0] core_sym;

  // The slot can take a new symbol when empty or being drained this cycle.
  assign slot_free = ~valid_q | tx_ready;
  assign din_ready = slot_free & (state_q != TAIL);
  assign accept    = din_valid & din_ready;
  assign tail_fire = slot_free & (state_q == TAIL);
  // In IDLE bit_cnt_q is 0, so a one-bit frame is also "last" on its first bit.
  assign last_bit  = (bit_cnt_q == LAST_CNT);
  assign last_tail = (tail_cnt_q == 2'd2);
  // Tail symbols are encoded with a forced zero input bit.
  assign core_bit  = (state_q == TAIL) ? 1'b0 : din;
  assign shift_en  = accept | tail_fire;

  conv_enc213_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .shift_en_i (shift_en),
    .bit_i      (core_bit),
    .clear_i    (1'b0),
    .sym_o      (core_sym)
  );

  // Frame FSM: info-bit counting and tail sequencing.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          if (last_bit) begin
            bit_cnt_d = {CNT_W{1'b0}};
            state_d   = TAIL_EN ? TAIL : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            state_d   = DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      TAIL: begin
        if (slot_free) begin
          if (last_tail) begin
            tail_cnt_d = 2'd0;
            state_d    = IDLE;
          end else begin
            tail_cnt_d = tail_cnt_q + 2'd1;
          end
        end else begin
          tail_cnt_d = tail_cnt_q;
        end
      end
      default: begin
        state_d    = IDLE;
        bit_cnt_d  = {CNT_W{1'b0}};
        tail_cnt_d = 2'd0;
      end
    endcase
  end

  // Output slot: load a new symbol, drain, or hold stable under backpressure.
  always_comb begin
    tx_d    = tx_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (shift_en) begin
      tx_d    = core_sym;
      valid_d = 1'b1;
      sop_d   = accept & (state_q == IDLE);
      eop_d   = (accept & last_bit & ~TAIL_EN) | (tail_fire & last_tail);
    end else if (slot_free) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end else begin
      tx_d    = tx_q;
    end
  end

  // State, counter and output-slot registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= {CNT_W{1'b0}};
      tail_cnt_q <= 2'd0;
      tx_q       <= 2'b00;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      tx_q       <= tx_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
    end
  end

  assign Tx       = tx_q;
  assign tx_valid = valid_q;
  assign tx_sop   = sop_q;
  assign tx_eop   = eop_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_conv_encoder_213.sv
// -----------------------------------------------------------------------------
// tb_conv_encoder_213
// Self-checking bench for conv_encoder_213. A main instance (FRAME_LEN=8) is
// driven by directed and random handshake traffic and compared symbol by
// symbol against a bit-history reference encoder; a second instance
// (FRAME_LEN=1) covers the single-bit frame. Honours CONV_ENC_TAIL_FLUSH_EN.
// -----------------------------------------------------------------------------
module tb_conv_encoder_213;

  localparam int FL = 8;
`ifdef CONV_ENC_TAIL_FLUSH_EN
  localparam int TAIL_ON = 1;
`else
  localparam int TAIL_ON = 0;
`endif
  localparam int SPF = FL + 3 * TAIL_ON;  // symbols per frame
  localparam int NS1 = 1 + 3 * TAIL_ON;   // symbols per frame, FRAME_LEN=1

  logic       clock;
  logic       reset;
  logic       din, din_valid, din_ready;
  logic [1:0] Tx;
  logic       tx_valid, tx_ready, tx_sop, tx_eop, busy;
  logic       din1, din1_valid, din1_ready;
  logic [1:0] tx1;
  logic       tx1_valid, tx1_ready, tx1_sop, tx1_eop, busy1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int cyc     = 0;

  // reference model state: previous three info bits, newest first
  int         h1 = 0, h2 = 0, h3 = 0;
  int         m_cnt = 0;
  logic [3:0] exp_q[$];
  logic       last_in_hs = 1'b0;
  logic       stall_prev = 1'b0;
  logic [3:0] held = 4'd0;
  logic       track = 1'b0;
  int         vfirst = -1, vlast = -1;

  logic [4:0] exp_b[SPF];
  logic [4:0] exp_1[NS1];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  conv_encoder_213 #(.FRAME_LEN(FL)) dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .Tx(Tx), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy)
  );

  conv_encoder_213 #(.FRAME_LEN(1)) dut1 (
    .clock(clock), .reset(reset), .din(din1), .din_valid(din1_valid),
    .din_ready(din1_ready), .Tx(tx1), .tx_valid(tx1_valid), .tx_ready(tx1_ready),
    .tx_sop(tx1_sop), .tx_eop(tx1_eop), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One code symbol from the generator taps: G0 = all four bits,
  // G1 = current, 1-ago and 3-ago bits; parity is the sum mod 2.
  function automatic void model_emit(input int b, input logic sop, input logic eop);
    int p0, p1;
    p0 = (b + h1 + h2 + h3) % 2;
    p1 = (b + h1 + h3) % 2;
    exp_q.push_back({p0[0], p1[0], sop, eop});
    h3 = h2;
    h2 = h1;
    h1 = b;
  endfunction

  function automatic void model_in(input logic b);
    logic sop, last;
    sop   = (m_cnt == 0);
    last  = (m_cnt == FL - 1);
    m_cnt = last ? 0 : m_cnt + 1;
    if (TAIL_ON != 0) begin
      model_emit(int'(b), sop, 1'b0);
      if (last) begin
        model_emit(0, 1'b0, 1'b0);
        model_emit(0, 1'b0, 1'b0);
        model_emit(0, 1'b0, 1'b1);
      end
    end else begin
      model_emit(int'(b), sop, last);
    end
  endfunction

  // Mid-cycle monitor for the main instance: scoreboard, hold check, gap tracking.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        exp_q.delete();
        h1 = 0; h2 = 0; h3 = 0;
        m_cnt = 0;
        stall_prev = 1'b0;
        last_in_hs = 1'b0;
      end else begin
        if (stall_prev)
          check("hold", 32'({tx_valid, Tx, tx_sop, tx_eop}), 32'({1'b1, held}));
        if (track && tx_valid) begin
          if (vfirst < 0) vfirst = cyc;
          vlast = cyc;
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0)
            check("sym_unexpected", 32'(exp_q.size()), 32'd1);
          else
            check("sym", 32'({Tx, tx_sop, tx_eop}), 32'(exp_q.pop_front()));
        end
        last_in_hs = din_valid && din_ready;
        if (last_in_hs) begin
          model_in(din);
          n_acc++;
        end
        stall_prev = tx_valid && !tx_ready;
        held = {Tx, tx_sop, tx_eop};
      end
    end
  end

  task automatic run_bits(input int nbits, input int pv, input int pr);
    int target, guard, limit;
    target = n_acc + nbits;
    guard  = 0;
    limit  = nbits * 20 + 100;
    forever begin
      @(posedge clock); #2;
      if (n_acc >= target || guard >= limit) break;
      guard++;
      if (!din_valid || last_in_hs) begin
        din_valid = ($urandom_range(99) < pv);
        din       = 1'($urandom_range(1));
      end
      tx_ready = ($urandom_range(99) < pr);
    end
    din_valid = 1'b0;
    if (guard >= limit) check("run_timeout", 32'(n_acc), 32'(target));
  endtask

  task automatic drain();
    int g;
    tx_ready = 1'b1;
    g = 0;
    while ((exp_q.size() != 0 || tx_valid) && g < 100) begin
      @(posedge clock); #2;
      g++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
`ifdef CONV_ENC_TAIL_FLUSH_EN
    exp_b = '{5'b1_11_1_0, 5'b1_00_0_0, 5'b1_10_0_0, 5'b1_01_0_0, 5'b1_01_0_0,
              5'b1_01_0_0, 5'b1_01_0_0, 5'b1_01_0_0, 5'b1_10_0_0, 5'b1_01_0_0,
              5'b1_11_0_1};
    exp_1 = '{5'b1_11_1_0, 5'b1_11_0_0, 5'b1_10_0_0, 5'b1_11_0_1};
`else
    exp_b = '{5'b1_11_1_0, 5'b1_00_0_0, 5'b1_10_0_0, 5'b1_01_0_0, 5'b1_01_0_0,
              5'b1_01_0_0, 5'b1_01_0_0, 5'b1_01_0_1};
    exp_1 = '{5'b1_11_1_1};
`endif
    reset = 1'b1;
    din = 1'b0; din_valid = 1'b0; tx_ready = 1'b0;
    din1 = 1'b0; din1_valid = 1'b0; tx1_ready = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // reset state
    @(negedge clock);
    check("rst_tx", 32'(Tx), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_sop", 32'(tx_sop), 32'd0);
    check("rst_eop", 32'(tx_eop), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_sr", 32'(dut.u_core.sr_q), 32'd0);

    // impulse into the single-bit-frame instance
    @(posedge clock); #2;
    din1 = 1'b1; din1_valid = 1'b1;
    @(posedge clock); #2;
    din1_valid = 1'b0;
    for (int k = 0; k < NS1; k++) begin
      @(negedge clock);
      check("fl1_sym", 32'({tx1_valid, tx1, tx1_sop, tx1_eop}), 32'(exp_1[k]));
      if (k == 0) check("fl1_din_ready", 32'(din1_ready), 32'(1 - TAIL_ON));
    end
    @(negedge clock);
    check("fl1_idle", 32'({tx1_valid, busy1}), 32'd0);
    check("fl1_sr", 32'(dut1.u_core.sr_q), 32'(TAIL_ON != 0 ? 3'b000 : 3'b100));

    // all-ones frame with 1-cycle latency and full throughput
    @(posedge clock); #2;
    din = 1'b1; din_valid = 1'b1; tx_ready = 1'b1;
    @(negedge clock);
    for (int k = 0; k < SPF; k++) begin
      if (k == FL - 1) begin
        @(posedge clock); #2;
        din_valid = 1'b0;
      end
      @(negedge clock);
      check("ones_sym", 32'({tx_valid, Tx, tx_sop, tx_eop}), 32'(exp_b[k]));
    end
    @(negedge clock);
    check("ones_end_valid", 32'(tx_valid), 32'd0);
    check("ones_sr", 32'(dut.u_core.sr_q), 32'(TAIL_ON != 0 ? 3'b000 : 3'b111));

    // two back-to-back frames: symbols must be contiguous
    @(posedge clock); #2;
    vfirst = -1; vlast = -1; track = 1'b1;
    run_bits(2 * FL, 100, 100);
    drain();
    track = 1'b0;
    check("b2b_span", 32'(vlast - vfirst + 1), 32'(2 * SPF));

    // backpressure for 5 cycles mid-frame
    run_bits(3, 100, 100);
    din = 1'($urandom_range(1)); din_valid = 1'b1; tx_ready = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("bp_din_ready", 32'(din_ready), 32'd0);
      check("bp_valid", 32'(tx_valid), 32'd1);
    end
    run_bits(FL - 3, 100, 100);
    drain();

    // reset in the middle of a frame
    run_bits(5, 100, 100);
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_din_ready", 32'(din_ready), 32'd1);
    check("mid_rst_sr", 32'(dut.u_core.sr_q), 32'd0);
    run_bits(FL, 100, 100);
    drain();

    // random valid/ready over about 1000 frames
    run_bits(1000 * FL, 70, 60);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
